// File: rtl/simple_uart.sv
// simple_uart: single-clock UART with one transmitter and one receiver sharing
// a bit timing of BIT_TICKS = F_CLK_Hz / BAUD_RATE clock cycles per bit.
// Frame: start(0), data LSB first, optional even parity, stop(1).
// Define SIMPLE_UART_PARITY_EN to transmit/check the parity bit; without it the
// parity states are removed and crc_error is tied low.
module simple_uart #(
    parameter int DATA_N_BIT = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int F_CLK_Hz   = 100000000
) (
    input  logic                  clk,
    input  logic                  sync_rst_n,
    input  logic [DATA_N_BIT-1:0] din,
    input  logic                  din_valid,
    output logic                  ready,
    output logic                  uart_dout,
    input  logic                  uart_din,
    output logic [DATA_N_BIT-1:0] dout,
    output logic                  dout_valid,
    output logic                  crc_error,
    output logic                  uart_echo
);

    localparam int BIT_TICKS = F_CLK_Hz / BAUD_RATE;
    localparam int CNT_W     = $clog2(BIT_TICKS) + 1;
    localparam int BIT_W     = $clog2(DATA_N_BIT) + 1;
    localparam logic [CNT_W-1:0] BT_LAST   = CNT_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_TICKS / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_N_BIT - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA,
`ifdef SIMPLE_UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA,
`ifdef SIMPLE_UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP, RX_WAIT_IDLE
    } rx_state_t;

    // ---------------- transmitter ----------------
    tx_state_t             tx_state_q, tx_state_d;
    logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]      tx_bit_q, tx_bit_d;
    logic [DATA_N_BIT-1:0] tx_shift_q, tx_shift_d;
    logic                  tx_dout_q, tx_dout_d;
    logic                  tx_end;
`ifdef SIMPLE_UART_PARITY_EN
    logic                  tx_par_q, tx_par_d;
`endif

    assign tx_end    = (tx_cnt_q == BT_LAST);
    assign ready     = (tx_state_q == TX_IDLE);
    assign uart_dout = tx_dout_q;

    // TX next state: one BIT_TICKS period per state, DATA_N_BIT periods in DATA
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
`ifdef SIMPLE_UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        if (tx_state_q != TX_IDLE) begin
            tx_cnt_d = tx_end ? '0 : tx_cnt_q + 1'b1;
        end
        case (tx_state_q)
            TX_IDLE: begin
                if (din_valid) begin
                    tx_state_d = TX_START;
                    tx_shift_d = din;
`ifdef SIMPLE_UART_PARITY_EN
                    tx_par_d   = ^din;
`endif
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                end
            end
            TX_START: if (tx_end) tx_state_d = TX_DATA;
            TX_DATA: begin
                if (tx_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + 1'b1;
                    if (tx_bit_q == BIT_LAST) begin
`ifdef SIMPLE_UART_PARITY_EN
                        tx_state_d = TX_PARITY;
`else
                        tx_state_d = TX_STOP;
`endif
                    end
                end
            end
`ifdef SIMPLE_UART_PARITY_EN
            TX_PARITY: if (tx_end) tx_state_d = TX_STOP;
`endif
            TX_STOP: if (tx_end) tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
        // Line level follows the state being entered so the pin is glitch-free
        case (tx_state_d)
            TX_START:  tx_dout_d = 1'b0;
            TX_DATA:   tx_dout_d = tx_shift_d[0];
`ifdef SIMPLE_UART_PARITY_EN
            TX_PARITY: tx_dout_d = tx_par_d;
`endif
            default:   tx_dout_d = 1'b1;
        endcase
    end

    // TX control registers; reset aborts any frame and returns the line high
    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_dout_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_dout_q  <= tx_dout_d;
        end
    end

    // ---------------- receiver ----------------
    logic                  rx_sync1_q, rx_sync2_q, rx_prev_q;
    rx_state_t             rx_state_q, rx_state_d;
    logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]      rx_bit_q, rx_bit_d;
    logic [DATA_N_BIT-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_N_BIT-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
`ifdef SIMPLE_UART_PARITY_EN
    logic                  rx_par_q, rx_par_d;
    logic                  crc_q, crc_d;
    assign crc_error = crc_q;
`else
    assign crc_error = 1'b0;
`endif

    assign uart_echo  = rx_sync2_q;
    assign dout       = dout_q;
    assign dout_valid = valid_q;

    // RX next state: half-bit delay to mid start bit, then one sample per bit
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        dout_d     = dout_q;
        valid_d    = 1'b0;
`ifdef SIMPLE_UART_PARITY_EN
        rx_par_d   = rx_par_q;
        crc_d      = 1'b0;
`endif
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync2_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[DATA_N_BIT-1:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == BIT_LAST) begin
`ifdef SIMPLE_UART_PARITY_EN
                        rx_state_d = RX_PARITY;
`else
                        rx_state_d = RX_STOP;
`endif
                    end
                end
            end
`ifdef SIMPLE_UART_PARITY_EN
            RX_PARITY: begin
                if (rx_cnt_q == BT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = rx_sync2_q;
                    rx_state_d = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (rx_cnt_q == BT_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_sync2_q) begin
                        dout_d     = rx_shift_q;
                        valid_d    = 1'b1;
`ifdef SIMPLE_UART_PARITY_EN
                        crc_d      = (^rx_shift_q) ^ rx_par_q;
`endif
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_WAIT_IDLE;
                    end
                end
            end
            RX_WAIT_IDLE: begin
                rx_cnt_d = '0;
                if (rx_sync2_q) rx_state_d = RX_IDLE;
            end
            default: begin
                rx_cnt_d   = '0;
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // RX synchronizer and control registers; reset drops any partial word
    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
`ifdef SIMPLE_UART_PARITY_EN
            crc_q      <= 1'b0;
`endif
        end else begin
            rx_sync1_q <= uart_din;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
`ifdef SIMPLE_UART_PARITY_EN
            crc_q      <= crc_d;
`endif
        end
    end

    // Shift and parity data registers carry no reset; the FSMs gate their use
    always_ff @(posedge clk) begin
        tx_shift_q <= tx_shift_d;
        rx_shift_q <= rx_shift_d;
`ifdef SIMPLE_UART_PARITY_EN
        tx_par_q   <= tx_par_d;
        rx_par_q   <= rx_par_d;
`endif
    end

endmodule

// File: tb/tb_simple_uart.sv
// Directed testbench for simple_uart with DATA_N_BIT=6, BAUD_RATE=10,
// F_CLK_Hz=1000 (BIT_TICKS=100). Works with or without SIMPLE_UART_PARITY_EN.
module tb_simple_uart;

    localparam int DW = 6;
    localparam int BT = 100;
`ifdef SIMPLE_UART_PARITY_EN
    localparam int FRAME       = DW + 3;
    localparam bit EXP_BAD_CRC = 1'b1;
`else
    localparam int FRAME       = DW + 2;
    localparam bit EXP_BAD_CRC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          ready;
    logic          uart_dout;
    logic          uart_din;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          crc_error;
    logic          uart_echo;
    logic          loop_en = 1'b1;
    logic          drv_din = 1'b1;

    int checks = 0;
    int errors = 0;

    int            vcount = 0;
    logic [DW-1:0] last_dout = '0;
    logic          last_crc = 1'b0;
    int            crc_stray = 0;

    assign uart_din = loop_en ? uart_dout : drv_din;

    simple_uart #(
        .DATA_N_BIT(DW),
        .BAUD_RATE (10),
        .F_CLK_Hz  (1000)
    ) dut (
        .clk       (clk),
        .sync_rst_n(rst_n),
        .din       (din),
        .din_valid (din_valid),
        .ready     (ready),
        .uart_dout (uart_dout),
        .uart_din  (uart_din),
        .dout      (dout),
        .dout_valid(dout_valid),
        .crc_error (crc_error),
        .uart_echo (uart_echo)
    );

    always #5 clk = ~clk;

    // Record every received-word strobe and any crc_error outside a strobe
    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            vcount    = vcount + 1;
            last_dout = dout;
            last_crc  = crc_error;
        end
        if (crc_error === 1'b1 && dout_valid !== 1'b1) crc_stray = crc_stray + 1;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
        checks++; if (uart_dout !== 1'b1) begin errors++; $display("FAIL reset_dout_line got %b want 1", uart_dout); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL reset_dout got %0d want 0", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dout_valid); end
        checks++; if (crc_error !== 1'b0) begin errors++; $display("FAIL reset_crc got %b want 0", crc_error); end
        checks++; if (uart_echo !== 1'b1) begin errors++; $display("FAIL reset_echo got %b want 1", uart_echo); end
    endtask

    // Send one word over loopback; entered and left at a negedge with ready high
    task automatic tx_frame(input logic [DW-1:0] word, input logic [DW+2:0] exp_bits, input string tag);
        int k;
        int v0;
        v0 = vcount;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL %s_ready_before got %b want 1", tag, ready); end
        din       = word;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        k = 0;
        while (k < 3000) begin
            if ((k % BT) == BT / 2 && (k / BT) < FRAME) begin
                checks++;
                if (uart_dout !== exp_bits[k / BT]) begin
                    errors++;
                    $display("FAIL %s_bit%0d got %b want %b", tag, k / BT, uart_dout, exp_bits[k / BT]);
                end
            end
            if (ready === 1'b1) break;
            @(negedge clk);
            k++;
        end
        checks++; if (k != FRAME * BT) begin errors++; $display("FAIL %s_busy_cycles got %0d want %0d", tag, k, FRAME * BT); end
        checks++; if (vcount != v0 + 1) begin errors++; $display("FAIL %s_rx_strobes got %0d want %0d", tag, vcount - v0, 1); end
        checks++; if (last_dout !== word) begin errors++; $display("FAIL %s_rx_word got %0d want %0d", tag, last_dout, word); end
        checks++; if (last_crc !== 1'b0) begin errors++; $display("FAIL %s_rx_crc got %b want 0", tag, last_crc); end
    endtask

    // Drive a frame directly onto uart_din, leaving the line idle high
    task automatic drive_frame(input logic [DW-1:0] word, input logic par, input logic stop);
        drv_din = 1'b0;
        repeat (BT) @(negedge clk);
        for (int i = 0; i < DW; i++) begin
            drv_din = word[i];
            repeat (BT) @(negedge clk);
        end
`ifdef SIMPLE_UART_PARITY_EN
        drv_din = par;
        repeat (BT) @(negedge clk);
`endif
        drv_din = stop;
        repeat (BT) @(negedge clk);
        drv_din = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_tx_13();
        // start, 1,0,1,1,0,0, parity 1, stop
`ifdef SIMPLE_UART_PARITY_EN
        tx_frame(6'd13, 9'b110011010, "tx13");
`else
        tx_frame(6'd13, 9'b010011010, "tx13");
`endif
    endtask

    task automatic test_back_to_back();
        // accepted in the very cycle ready returned; all-zero word, parity 0
`ifdef SIMPLE_UART_PARITY_EN
        tx_frame(6'd0, 9'b100000000, "tx0");
`else
        tx_frame(6'd0, 9'b010000000, "tx0");
`endif
    endtask

    task automatic test_crc_error();
        int v0;
        loop_en = 1'b0;
        drv_din = 1'b1;
        repeat (20) @(negedge clk);
        v0 = vcount;
        drive_frame(6'd13, 1'b0, 1'b1);
        checks++; if (vcount != v0 + 1) begin errors++; $display("FAIL crc_strobes got %0d want 1", vcount - v0); end
        checks++; if (last_dout !== 6'd13) begin errors++; $display("FAIL crc_word got %0d want 13", last_dout); end
        checks++; if (last_crc !== EXP_BAD_CRC) begin errors++; $display("FAIL crc_flag got %b want %b", last_crc, EXP_BAD_CRC); end
    endtask

    task automatic test_framing();
        int v0;
        v0 = vcount;
        drive_frame(6'd21, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        checks++; if (vcount != v0) begin errors++; $display("FAIL frame_err_strobes got %0d want 0", vcount - v0); end
        checks++; if (dout !== 6'd13) begin errors++; $display("FAIL frame_err_hold got %0d want 13", dout); end
        drive_frame(6'd5, 1'b0, 1'b1);
        checks++; if (vcount != v0 + 1) begin errors++; $display("FAIL frame_recover_strobes got %0d want 1", vcount - v0); end
        checks++; if (last_dout !== 6'd5) begin errors++; $display("FAIL frame_recover_word got %0d want 5", last_dout); end
        checks++; if (last_crc !== 1'b0) begin errors++; $display("FAIL frame_recover_crc got %b want 0", last_crc); end
    endtask

    task automatic test_glitch();
        int v0;
        v0 = vcount;
        drv_din = 1'b0;
        repeat (10) @(negedge clk);
        drv_din = 1'b1;
        repeat (50) @(negedge clk);
        checks++; if (vcount != v0) begin errors++; $display("FAIL glitch_strobes got %0d want 0", vcount - v0); end
        drive_frame(6'd9, 1'b0, 1'b1);
        checks++; if (vcount != v0 + 1) begin errors++; $display("FAIL glitch_rearm_strobes got %0d want 1", vcount - v0); end
        checks++; if (last_dout !== 6'd9) begin errors++; $display("FAIL glitch_rearm_word got %0d want 9", last_dout); end
    endtask

    task automatic test_reset_midframe();
        int v0;
        int lows;
        loop_en = 1'b1;
        repeat (5) @(negedge clk);
        v0 = vcount;
        din       = 6'd13;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        repeat (150) @(negedge clk);
        din       = 6'd7;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL busy_ready got %b want 0", ready); end
        repeat (99) @(negedge clk);
        // cycle 250: data bit 1 of 13 is 0
        checks++; if (uart_dout !== 1'b0) begin errors++; $display("FAIL busy_bit2 got %b want 0", uart_dout); end
        repeat (300) @(negedge clk);
        // cycle 550: data bit 4 of 13 is 0
        checks++; if (uart_dout !== 1'b0) begin errors++; $display("FAIL busy_bit5 got %b want 0", uart_dout); end
        rst_n = 1'b0;
        #1;
        checks++; if (uart_dout !== 1'b1) begin errors++; $display("FAIL abort_line got %b want 1", uart_dout); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", ready); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (uart_dout !== 1'b1) lows++;
        end
        checks++; if (lows != 0) begin errors++; $display("FAIL abort_no_resend got %0d low cycles want 0", lows); end
        checks++; if (vcount != v0) begin errors++; $display("FAIL abort_rx_strobes got %0d want 0", vcount - v0); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL abort_dout got %0d want 0", dout); end
    endtask

    initial begin
        test_reset();
        test_tx_13();
        test_back_to_back();
        test_crc_error();
        test_framing();
        test_glitch();
        test_reset_midframe();
        checks++; if (crc_stray != 0) begin errors++; $display("FAIL crc_outside_strobe got %0d want 0", crc_stray); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
